serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor: computes D = X - Y - Bin, one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a borrow flip-flop.
- Sequential counterpart to the team's ripple-carry adder; shares the same LEDR result mapping for board bring-up.
- Start/Busy/Done handshake lets a controller FSM or board switches (via a debounced key) launch operations.

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/full_subtractor.sv | 28 ++
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width of the board LED bus.
package serial_sub_pkg;

   localparam int unsigned LEDR_W = 10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// With SERIAL_SUB_ADD_MODE_EN defined the bundle also carries the Add select.
interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
);
   logic              Start;
   logic [WIDTH-1:0]  X;
   logic [WIDTH-1:0]  Y;
   logic              Bin;
   logic              Busy;
   logic              Done;
   logic [WIDTH-1:0]  D;
   logic              Bout;
   logic              V;
   logic [LEDR_W-1:0] LEDR;
`ifdef SERIAL_SUB_ADD_MODE_EN
   logic              Add;

   modport master (output Start, X, Y, Bin, Add,
                   input  Busy, Done, D, Bout, V, LEDR);
   modport slave  (input  Start, X, Y, Bin, Add,
                   output Busy, Done, D, Bout, V, LEDR);
`else
   modport master (output Start, X, Y, Bin,
                   input  Busy, Done, D, Bout, V, LEDR);
   modport slave  (input  Start, X, Y, Bin,
                   output Busy, Done, D, Bout, V, LEDR);
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell. With SERIAL_SUB_ADD_MODE_EN defined an add
// select turns it into a full adder (bout then carries carry-out).
module full_subtractor (
`ifdef SERIAL_SUB_ADD_MODE_EN
   input  logic add,
`endif
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference/sum bit is the same xor in both modes; only the borrow/carry differs.
   always_comb begin
      d = a ^ b ^ bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
      if (add) begin
         bout = (a & b) | (a & bin) | (b & bin);
      end else begin
         bout = (~a & b) | (~(a ^ b) & bin);
      end
`else
      bout = (~a & b) | (~(a ^ b) & bin);
`endif
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y - Bin, one bit per clock, LSB first.
// Optional SERIAL_SUB_ADD_MODE_EN adds an Add select (D = X + Y + Bin).
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input logic               Clock,
   input logic               Reset,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned EXT_W = LEDR_W + WIDTH + 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             br_q, br_d;
   // Operand MSBs kept aside because A and B are shifted away during RUN.
   logic             x_msb_q, x_msb_d;
   logic             y_msb_q, y_msb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bout_q, bout_d;
   logic             v_q, v_d;
   logic             cell_d, cell_bout;
   logic             ovf_sub;
   logic [EXT_W-1:0] ledr_ext;
`ifdef SERIAL_SUB_ADD_MODE_EN
   logic             add_q, add_d;
   logic             ovf_add;
`endif

   full_subtractor u_cell (
`ifdef SERIAL_SUB_ADD_MODE_EN
      .add  (add_q),
`endif
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Overflow from the captured MSBs and the final (MSB) result bit.
   always_comb begin
      ovf_sub = (x_msb_q != y_msb_q) && (cell_d != x_msb_q);
`ifdef SERIAL_SUB_ADD_MODE_EN
      ovf_add = (x_msb_q == y_msb_q) && (cell_d != x_msb_q);
`endif
   end

   // FSM next state, operand capture, shifting and result load.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      x_msb_d = x_msb_q;
      y_msb_d = y_msb_q;
      res_d   = res_q;
      bout_d  = bout_q;
      v_d     = v_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
      add_d   = add_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.Start) begin
               a_d     = bus.X;
               b_d     = bus.Y;
               br_d    = bus.Bin;
               x_msb_d = bus.X[WIDTH-1];
               y_msb_d = bus.Y[WIDTH-1];
               r_d     = '0;
               cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
               add_d   = bus.Add;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            r_d   = {cell_d, r_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = cell_bout;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               res_d   = {cell_d, r_q[WIDTH-1:1]};
               bout_d  = cell_bout;
`ifdef SERIAL_SUB_ADD_MODE_EN
               v_d     = add_q ? ovf_add : ovf_sub;
`else
               v_d     = ovf_sub;
`endif
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         x_msb_q <= 1'b0;
         y_msb_q <= 1'b0;
         res_q   <= '0;
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
         add_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         x_msb_q <= x_msb_d;
         y_msb_q <= y_msb_d;
         res_q   <= res_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
         add_q   <= add_d;
`endif
      end
   end

   // Outputs; LEDR shows {Bout, D} zero-extended, truncated when WIDTH >= LEDR_W.
   always_comb begin
      ledr_ext = EXT_W'({bout_q, res_q});
      bus.Busy = (state_q == StRun);
      bus.Done = (state_q == StDone);
      bus.D    = res_q;
      bus.Bout = bout_q;
      bus.V    = v_q;
      bus.LEDR = ledr_ext[LEDR_W-1:0];
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4). Covers Add mode when
// SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         v;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     n_tests = 0;
   int     n_fail = 0;
   int     n_done = 0;
   int     cyc = 0;
   int     last_done_cyc = 0;
   int     gaps[$];
   exp_t   sb_q[$];
   logic [W-1:0] last_d = '0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic bin, input logic add);
      logic [W:0] full;
      exp_t       e;
      if (add) begin
         full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, bin};
         e.v  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      end else begin
         full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
         e.v  = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
      end
      e.d    = full[W-1:0];
      e.bout = full[W];
      return e;
   endfunction

   // Compare every Done pulse against the oldest pending expectation.
   always @(negedge clk) begin
      if (bus.Done === 1'b1) begin
         exp_t e;
         n_done++;
         gaps.push_back(cyc - last_done_cyc);
         last_done_cyc = cyc;
         chk("sb_nonempty_on_done", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("D", 32'(bus.D), 32'(e.d));
            chk("Bout", 32'(bus.Bout), 32'(e.bout));
            chk("V", 32'(bus.V), 32'(e.v));
            chk("LEDR", 32'(bus.LEDR), {22'd0, 5'd0, e.bout, e.d});
         end
      end
   end

   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                        input logic add);
      bus.X   = x;
      bus.Y   = y;
      bus.Bin = bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
      bus.Add = add;
`endif
   endtask

   // One operation with timing checks; glitch>0 re-pulses Start in that cycle.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                         input logic add, input int glitch);
      exp_t e;
      e = model(x, y, bin, add);
      @(negedge clk);
      drive(x, y, bin, add);
      bus.Start = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 1; c <= int'(W) + 1; c++) begin
         @(negedge clk);
         chk("busy", 32'(bus.Busy), 32'(c <= int'(W)));
         chk("done", 32'(bus.Done), 32'(c == int'(W) + 1));
         if (c <= int'(W)) chk("d_hold", 32'(bus.D), 32'(last_d));
         if (c == glitch) begin
            drive(4'hF, 4'hF, 1'b0, 1'b0);
            bus.Start = 1'b1;
         end else begin
            bus.Start = 1'b0;
         end
      end
      bus.Start = 1'b0;
      last_d = e.d;
   endtask

   initial begin
      int n0;
      bus.Start = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.Busy), 32'd0);
      chk("rst_done", 32'(bus.Done), 32'd0);
      chk("rst_d", 32'(bus.D), 32'd0);
      chk("rst_bout", 32'(bus.Bout), 32'd0);
      chk("rst_v", 32'(bus.V), 32'd0);
      chk("rst_ledr", 32'(bus.LEDR), 32'd0);
      rst = 1'b0;

      run_op(4'd9, 4'd3, 1'b0, 1'b0, 0);
      run_op(4'd3, 4'd9, 1'b0, 1'b0, 0);
      run_op(4'd0, 4'd0, 1'b1, 1'b0, 0);
      run_op(4'd8, 4'd1, 1'b0, 1'b0, 0);
      // Start during RUN (mid and last cycle) must be dropped.
      run_op(4'd9, 4'd3, 1'b0, 1'b0, 2);
      run_op(4'd9, 4'd3, 1'b0, 1'b0, int'(W));
      for (int i = 0; i < 8; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
      end
`ifdef SERIAL_SUB_ADD_MODE_EN
      run_op(4'd9, 4'd8, 1'b1, 1'b1, 0);
      run_op(4'd9, 4'd8, 1'b1, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
      end
`endif

      // Start held high: accepts at edges 0, 6, 12.
      @(negedge clk);
      n0 = n_done;
      for (int i = 0; i < 3; i++) sb_q.push_back(model(4'd5, 4'd2, 1'b0, 1'b0));
      drive(4'd5, 4'd2, 1'b0, 1'b0);
      bus.Start = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_done_count", 32'(n_done - n0), 32'd3);
      chk("held_gap_a", 32'(gaps[gaps.size()-1]), 32'(W + 2));
      chk("held_gap_b", 32'(gaps[gaps.size()-2]), 32'(W + 2));
      last_d = 4'd3;

      // Reset on the second RUN cycle aborts the operation.
      @(negedge clk);
      drive(4'd9, 4'd3, 1'b0, 1'b0);
      bus.Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(bus.Busy), 32'd0);
      chk("abort_done", 32'(bus.Done), 32'd0);
      chk("abort_d", 32'(bus.D), 32'd0);
      chk("abort_ledr", 32'(bus.LEDR), 32'd0);
      rst = 1'b0;
      n0 = n_done;
      repeat (10) @(negedge clk);
      chk("abort_no_done", 32'(n_done - n0), 32'd0);
      last_d = '0;

      run_op(4'd9, 4'd3, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
